// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the multiply/divide unit: opcode and FSM state encodings.
package mdu_defs_pkg;

  localparam int unsigned MDU_WIDTH_DEFAULT = 32;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_DZERO,
    ST_FINISH
  } state_e;

  // One iteration per operand bit for both Booth and restoring division.
  function automatic int unsigned mdu_iter(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per enabled step.
module mdu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Partial remainder stays below the divisor, so WIDTH bits hold it; the
  // shifted trial value needs one more bit and the subtraction one more again.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (load) begin
      dvs_q <= divisor;
      quo_q <= dividend;
      rem_q <= '0;
    end else if (step) begin
      quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
      rem_q <= diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit with HI/LO.
// Optional MDU_UNSIGNED_EN enables multu/divu selection through the uns input.
module mult_div_unit
  import mdu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             uns,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned ITER = mdu_iter(WIDTH);
  localparam int unsigned CW   = $clog2(ITER + 1);

  state_e state, state_next;

  logic [CW-1:0]    count;
  logic             iter_done;
  logic             load;
  logic [WIDTH-1:0] a_reg;
  logic             b_msb;
  logic             dz_reg;
  logic             signed_in;
  logic             signed_reg;

  // Booth accumulator: {acc_a, acc_q} plus the trailing q_prev bit.
  logic [WIDTH:0]   acc_a;
  logic [WIDTH-1:0] acc_q;
  logic             q_prev;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] booth_sum;

  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_we;

`ifdef MDU_UNSIGNED_EN
  assign signed_in = ~uns;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signed_reg <= 1'b1;
    end else if (load) begin
      signed_reg <= ~uns;
    end
  end
`else
  logic unused_uns;
  assign unused_uns = uns;
  assign signed_in  = 1'b1;
  assign signed_reg = 1'b1;
`endif

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  assign load      = (state == ST_IDLE) && start;
  assign iter_done = (count == CW'(ITER));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op_e'(op) == OP_DIV) begin
            state_next = (b_in == '0) ? ST_DZERO : ST_DIV;
          end else begin
            state_next = ST_MULT;
          end
        end
      end
      ST_MULT,
      ST_DIV:    if (iter_done) state_next = ST_FINISH;
      ST_DZERO:  state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign busy    = (state == ST_MULT) || (state == ST_DIV) || (state == ST_DZERO);
  assign done    = (state == ST_FINISH);
  assign divZero = done && dz_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      a_reg  <= '0;
      b_msb  <= 1'b0;
      dz_reg <= 1'b0;
    end else if (load) begin
      count  <= '0;
      a_reg  <= a_in;
      b_msb  <= b_in[WIDTH-1];
      dz_reg <= (op_e'(op) == OP_DIV) && (b_in == '0);
    end else if ((state == ST_MULT || state == ST_DIV) && !iter_done) begin
      count <= count + CW'(1);
    end
  end

  // Sum is formed one bit wider than acc_a; after the arithmetic shift it fits again.
  always_comb begin
    m_ext = signed_reg ? {{2{a_reg[WIDTH-1]}}, a_reg} : {2'b00, a_reg};
    case ({acc_q[0], q_prev})
      2'b01:   booth_sum = {acc_a[WIDTH], acc_a} + m_ext;
      2'b10:   booth_sum = {acc_a[WIDTH], acc_a} - m_ext;
      default: booth_sum = {acc_a[WIDTH], acc_a};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_a  <= '0;
      acc_q  <= '0;
      q_prev <= 1'b0;
    end else if (load) begin
      acc_a  <= '0;
      acc_q  <= b_in;
      q_prev <= 1'b0;
    end else if (state == ST_MULT && !iter_done) begin
      acc_a  <= booth_sum[WIDTH+1:1];
      acc_q  <= {booth_sum[0], acc_q[WIDTH-1:1]};
      q_prev <= acc_q[0];
    end
  end

  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      ((state == ST_DIV) && !iter_done),
    .dividend  (magnitude(a_in, signed_in)),
    .divisor   (magnitude(b_in, signed_in)),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Booth treats the multiplier as signed; an unsigned multiplier with its
  // top bit set is short by multiplicand * 2^WIDTH, restored into HI here.
  always_comb begin
    res_we = (state == ST_MULT || state == ST_DIV) && iter_done;
    if (state == ST_MULT) begin
      res_hi = acc_a[WIDTH-1:0] + ((!signed_reg && b_msb) ? a_reg : '0);
      res_lo = acc_q;
    end else begin
      res_hi = (signed_reg && a_reg[WIDTH-1]) ? (~div_rem + 1'b1) : div_rem;
      res_lo = (signed_reg && (a_reg[WIDTH-1] ^ b_msb)) ? (~div_quo + 1'b1) : div_quo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (res_we) begin
      HI <= res_hi;
      LO <= res_lo;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, queue of expected results.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         uns = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic         divZero;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  mult_div_unit #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .uns     (uns),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .divZero (divZero),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  at;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_hi"},      64'(HI),      64'(e.hi));
        chk({e.name, "_lo"},      64'(LO),      64'(e.lo));
        chk({e.name, "_divzero"}, 64'(divZero), 64'(e.dz));
        chk({e.name, "_latency"}, 64'(cyc),     64'(e.at));
        chk({e.name, "_busy"},    64'(busy),    64'(0));
      end
    end
  end

  task automatic issue(input string name, input logic op_i, input logic uns_i,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi, input logic [W-1:0] lo,
                       input logic dz, input bit expect_done);
    @(negedge clk);
    op    = op_i;
    uns   = uns_i;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    if (expect_done) exp_q.push_back('{name, hi, lo, dz, cyc + (dz ? 2 : W + 2)});
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no done within 80 cycles, required done", name);
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic op_i, input logic uns_i,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
    issue(name, op_i, uns_i, a, b, hi, lo, dz, 1'b1);
    wait_done(name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",    64'(busy),    64'(0));
    chk("rst_done",    64'(done),    64'(0));
    chk("rst_divzero", 64'(divZero), 64'(0));
    chk("rst_hi",      64'(HI),      64'(0));
    chk("rst_lo",      64'(LO),      64'(0));

    run("mult_7_m3",  1'b0, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run("div_m7_2",   1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div_5_0",    1'b1, 1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);

    // Second start mid-operation must be dropped; HI/LO hold until completion.
    issue("mult_max", 1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("mid_busy",    64'(busy), 64'(1));
    chk("mid_hi_hold", 64'(HI),   64'(32'hFFFFFFFF));
    chk("mid_lo_hold", 64'(LO),   64'(32'hFFFFFFFD));
    op    = 1'b0;
    a_in  = 32'd3;
    b_in  = 32'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mult_max");

    run("div_ovf",    1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run("div_7_m2",   1'b1, 1'b0, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run("div_m7_m2",  1'b1, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0);
    run("mult_min2",  1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run("mult_minmx", 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0);
    run("mult_m1m1",  1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    run("mult_x0",    1'b0, 1'b0, 32'd5,        32'd0,        32'h00000000, 32'h00000000, 1'b0);
`ifdef MDU_UNSIGNED_EN
    run("multu",      1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0);
    run("divu",       1'b1, 1'b1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, 1'b0);
`else
    run("mult_uns_ign", 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,      32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run("div_uns_ign",  1'b1, 1'b1, 32'hFFFFFFFF, 32'd2,      32'hFFFFFFFF, 32'h00000000, 1'b0);
`endif

    // Abort a division around cycle 15: outputs clear at once, no done follows.
    issue("div_abort", 1'b1, 1'b0, 32'd100, 32'd7, '0, '0, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hi",   64'(HI),   64'(0));
    chk("abort_lo",   64'(LO),   64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_idle", 64'(busy), 64'(0));

    run("div_100_7",  1'b1, 1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
